// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Multi-cycle control FSM for the simple RISC CPU. Sequences
//                reset, fetch, decode and execute for MOV, ALU, CMP, LDR, STR
//                and HALT, with a ready/hold memory handshake and a sticky
//                watchdog timeout. Optional branch support (B<cond>, BL) is
//                enabled by defining MULTICYCLE_CTRL_BRANCH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 255,
    parameter int UNDEF_HALT  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode_i,
    input  logic [1:0] op_i,
    input  logic [2:0] cond_i,
    input  logic       flag_z_i,
    input  logic       flag_n_i,
    input  logic       flag_v_i,
    input  logic       mem_ready_i,
    output logic       loada_o,
    output logic       loadb_o,
    output logic       loadc_o,
    output logic       loads_o,
    output logic       write_o,
    output logic [2:0] nsel_o,
    output logic [1:0] vsel_o,
    output logic [1:0] sel_o,
    output logic       reset_pc_o,
    output logic       load_pc_o,
    output logic       addr_sel_o,
    output logic       load_ir_o,
    output logic       load_addr_o,
    output logic [1:0] pc_sel_o,
    output logic [1:0] mem_cmd_o,
    output logic       halted_o,
    output logic       timeout_err_o,
    output logic [4:0] state_dbg_o
);

    localparam logic [4:0] S_RST       = 5'd0;
    localparam logic [4:0] S_IF1       = 5'd1;
    localparam logic [4:0] S_IF2       = 5'd2;
    localparam logic [4:0] S_UPDATE_PC = 5'd3;
    localparam logic [4:0] S_DECODE    = 5'd4;
    localparam logic [4:0] S_GETA      = 5'd5;
    localparam logic [4:0] S_GETB      = 5'd6;
    localparam logic [4:0] S_ALU       = 5'd7;
    localparam logic [4:0] S_WREG      = 5'd8;
    localparam logic [4:0] S_WIMM      = 5'd9;
    localparam logic [4:0] S_COMP      = 5'd10;
    localparam logic [4:0] S_ADDR      = 5'd11;
    localparam logic [4:0] S_LADDR     = 5'd12;
    localparam logic [4:0] S_MRD       = 5'd13;
    localparam logic [4:0] S_WMEM      = 5'd14;
    localparam logic [4:0] S_GETD      = 5'd15;
    localparam logic [4:0] S_PASS      = 5'd16;
    localparam logic [4:0] S_MWR       = 5'd17;
    localparam logic [4:0] S_HALT      = 5'd18;
`ifdef MULTICYCLE_CTRL_BRANCH_EN
    localparam logic [4:0] S_BR        = 5'd19;
    localparam logic [4:0] S_BL        = 5'd20;
`endif

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RM = 3'b010;
    localparam logic [2:0] NSEL_RD = 3'b100;

    localparam logic [TIMEOUT_W-1:0] C_TMAX = TIMEOUT_W'(TIMEOUT_MAX);
    localparam logic [4:0] C_UNDEF_NEXT = (UNDEF_HALT != 0) ? S_HALT : S_IF1;

    logic [4:0]           state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [4:0]           mem_done_d;
    logic                 br_taken;

    // State, watchdog counter and sticky error register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Destination once the current memory wait state sees mem_ready
    always_comb begin
        mem_done_d = S_IF2;
        if (state_q == S_MRD) begin
            mem_done_d = S_WMEM;
        end else if (state_q == S_MWR) begin
            mem_done_d = S_IF1;
        end
    end

`ifdef MULTICYCLE_CTRL_BRANCH_EN
    // Branch condition evaluation from the status flags
    always_comb begin
        br_taken = 1'b0;
        case (cond_i)
            3'b000:  br_taken = 1'b1;
            3'b001:  br_taken = flag_z_i;
            3'b010:  br_taken = ~flag_z_i;
            3'b011:  br_taken = flag_n_i ^ flag_v_i;
            3'b100:  br_taken = (flag_n_i ^ flag_v_i) | flag_z_i;
            default: br_taken = 1'b0;
        endcase
    end
`else
    // Branch support absent: condition and flags are not consulted
    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{cond_i, flag_z_i, flag_n_i, flag_v_i};
    assign br_taken = 1'b0;
`endif

    // Next-state logic; the counter runs only while a memory state is held
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        err_d   = err_q;
        case (state_q)
            S_RST:       state_d = S_IF1;
            S_IF1, S_MRD, S_MWR: begin
                if (mem_ready_i) begin
                    state_d = mem_done_d;
                end else if (cnt_q == C_TMAX) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            S_IF2:       state_d = S_UPDATE_PC;
            S_UPDATE_PC: state_d = S_DECODE;
            S_DECODE: begin
                state_d = C_UNDEF_NEXT;
                if (opcode_i == 3'b111) begin
                    state_d = S_HALT;
                end else if (opcode_i == 3'b110 && op_i == 2'b10) begin
                    state_d = S_WIMM;
                end else if (opcode_i == 3'b110 && op_i == 2'b00) begin
                    state_d = S_GETB;
                end else if (opcode_i == 3'b101) begin
                    state_d = S_GETA;
                end else if ((opcode_i == 3'b011 || opcode_i == 3'b100) && op_i == 2'b00) begin
                    state_d = S_GETA;
`ifdef MULTICYCLE_CTRL_BRANCH_EN
                end else if (opcode_i == 3'b001 && op_i == 2'b00) begin
                    state_d = S_BR;
                end else if (opcode_i == 3'b010 && op_i == 2'b00) begin
                    state_d = S_BL;
`endif
                end
            end
            S_GETA: begin
                if (opcode_i == 3'b011 || opcode_i == 3'b100) begin
                    state_d = S_ADDR;
                end else if (op_i == 2'b11) begin
                    state_d = S_ALU;
                end else begin
                    state_d = S_GETB;
                end
            end
            S_GETB:      state_d = (opcode_i == 3'b101 && op_i == 2'b01) ? S_COMP : S_ALU;
            S_ALU:       state_d = S_WREG;
            S_WREG:      state_d = S_IF1;
            S_WIMM:      state_d = S_IF1;
            S_COMP:      state_d = S_IF1;
            S_ADDR:      state_d = S_LADDR;
            S_LADDR:     state_d = (opcode_i == 3'b011) ? S_MRD : S_GETD;
            S_WMEM:      state_d = S_IF1;
            S_GETD:      state_d = S_PASS;
            S_PASS:      state_d = S_MWR;
            S_HALT:      state_d = S_HALT;
`ifdef MULTICYCLE_CTRL_BRANCH_EN
            S_BR:        state_d = S_IF1;
            S_BL:        state_d = S_IF1;
`endif
            default:     state_d = S_RST;
        endcase
    end

    // Moore outputs per state, refined by decode inputs where needed
    always_comb begin
        loada_o     = 1'b0;
        loadb_o     = 1'b0;
        loadc_o     = 1'b0;
        loads_o     = 1'b0;
        write_o     = 1'b0;
        nsel_o      = 3'b000;
        vsel_o      = 2'b00;
        sel_o       = 2'b00;
        reset_pc_o  = 1'b0;
        load_pc_o   = 1'b0;
        addr_sel_o  = 1'b0;
        load_ir_o   = 1'b0;
        load_addr_o = 1'b0;
        pc_sel_o    = 2'b00;
        mem_cmd_o   = MNONE;
        halted_o    = 1'b0;
        case (state_q)
            S_RST:       begin reset_pc_o = 1'b1; load_pc_o = 1'b1; end
            S_IF1:       begin addr_sel_o = 1'b1; mem_cmd_o = MREAD; end
            S_IF2:       begin addr_sel_o = 1'b1; mem_cmd_o = MREAD; load_ir_o = 1'b1; end
            S_UPDATE_PC: load_pc_o = 1'b1;
            S_GETA:      begin nsel_o = NSEL_RN; loada_o = 1'b1; end
            S_GETB:      begin nsel_o = NSEL_RM; loadb_o = 1'b1; end
            S_ALU: begin
                loadc_o = 1'b1;
                if ((opcode_i == 3'b110 && op_i == 2'b00) || (opcode_i == 3'b101 && op_i == 2'b11)) begin
                    sel_o = 2'b01;
                end
            end
            S_WREG:      begin nsel_o = NSEL_RD; vsel_o = 2'b00; write_o = 1'b1; end
            S_WIMM:      begin nsel_o = NSEL_RN; vsel_o = 2'b10; write_o = 1'b1; end
            S_COMP:      loads_o = 1'b1;
            S_ADDR:      begin sel_o = 2'b10; loadc_o = 1'b1; end
            S_LADDR:     load_addr_o = 1'b1;
            S_MRD:       mem_cmd_o = MREAD;
            S_WMEM:      begin nsel_o = NSEL_RD; vsel_o = 2'b11; write_o = 1'b1; mem_cmd_o = MREAD; end
            S_GETD:      begin nsel_o = NSEL_RD; loadb_o = 1'b1; end
            S_PASS:      begin sel_o = 2'b01; loadc_o = 1'b1; end
            S_MWR:       mem_cmd_o = MWRITE;
            S_HALT:      halted_o = 1'b1;
`ifdef MULTICYCLE_CTRL_BRANCH_EN
            S_BR: begin
                if (br_taken) begin
                    load_pc_o = 1'b1;
                    pc_sel_o  = 2'b01;
                end
            end
            S_BL: begin
                nsel_o    = NSEL_RN;
                vsel_o    = 2'b01;
                write_o   = 1'b1;
                load_pc_o = 1'b1;
                pc_sel_o  = 2'b01;
            end
`endif
            default: ;
        endcase
    end

    assign timeout_err_o = err_q;
    assign state_dbg_o   = state_q;

endmodule
`default_nettype wire
